alu_arbiter: RTL

Sequencer and round-robin arbiter that shares the single combinational 8-bit ALU between two requesters (e.g. execute unit and address/compare unit). It accepts operation requests over valid/ready, drives the ALU operand and select lines from registered copies, and waits a configurable number of cycles for the slow multiply/divide codes. It then returns the tagged result over a back-pressured response channel and counts completed operations.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational 8-bit ALU between two requesters. A request is
//   accepted in IDLE through a round-robin grant. Its operands are then driven
//   to the ALU from registers. The ALU result is captured after an optional
//   settle wait for mul/div. The tagged result is held on a back-pressured
//   response channel until it is taken.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/ready       request handshake per requester
//   req{0,1}_a/_b/_sel         operation payload (valid only in the accept cycle)
//   alu_a, alu_b, alu_sel      registered operands/op code driven to the ALU
//   alu_out, alu_carry         ALU result and flag
//   rsp_valid/rsp_ready        response handshake
//   rsp_id, rsp_data, rsp_carry  owner and captured ALU result
//   busy                       high whenever the sequencer is not idle
//   op_count                   completed-operation counter (wraps at 256)
module alu_arbiter #(
  parameter int MULDIV_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT);

  logic [1:0] state;
  logic       prio;
  logic [3:0] wait_cnt;

  logic       grant;
  logic       in_idle;
  logic       accept;
  logic [7:0] acc_a;
  logic [7:0] acc_b;
  logic [2:0] acc_sel;
  logic       acc_muldiv;

  // With both requesters valid, prio decides. Otherwise the lone valid one
  // wins. grant is a don't-care when neither is valid.
  always_comb begin
    grant      = req1_valid & (~req0_valid | prio);
    // Readies are forced low while reset is asserted, even though the
    // state register already reads IDLE.
    in_idle    = (state == IDLE) & rst_n;
    req0_ready = in_idle & req0_valid & ~grant;
    req1_ready = in_idle & req1_valid & grant;
    accept     = req0_ready | req1_ready;
    acc_a      = grant ? req1_a   : req0_a;
    acc_b      = grant ? req1_b   : req0_b;
    acc_sel    = grant ? req1_sel : req0_sel;
    acc_muldiv = (acc_sel == 3'b101) || (acc_sel == 3'b110);
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      wait_cnt  <= 4'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_sel   <= 3'd0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_carry <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= acc_a;
            alu_b    <= acc_b;
            alu_sel  <= acc_sel;
            rsp_id   <= grant;
            wait_cnt <= acc_muldiv ? WAIT_LOAD : 4'd0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // The ALU inputs have been stable for 1 + wait cycles by the time
          // the counter reaches zero, so the result is safe to sample.
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            prio     <= ~rsp_id;
            op_count <= op_count + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
